sad_engine_param: RTL and testbench
===================================

# sad_engine_param

Parametrised sum-of-absolute-differences engine for block-matching motion estimation. It streams `NUM_BLKS` consecutive blocks of `BLK_PIXELS` pixels from two single-port frame memories (A = current, B = reference). It writes one 32-bit score per block to the score memory (C) and reports the index and value of the minimum-score block. It is the successor to the fixed 8-bit/256-pixel SAD block. New in this generation: configurable widths and depths, an SSD mode, saturating accumulation, abort, a busy flag, and best-match tracking.

## Interface
- `D_WIDTH`, default 8: pixel width (unsigned).
- `A_WIDTH`, default 15: A/B address width; must satisfy 2^A_WIDTH >= NUM_BLKS*BLK_PIXELS.
- `C_WIDTH`, default 7: score-memory address width; must satisfy 2^C_WIDTH >= NUM_BLKS.
- `BLK_PIXELS`, default 256: pixels per block, >= 1.
- `NUM_BLKS`, default 128: blocks per run, >= 1.
- `Clk` in, 1: the only clock; all logic on its rising edge.
- `Rst` in, 1: synchronous, active-high reset.
- `Go` in, 1: start request; sampled only in IDLE.
- `Abort` in, 1: cancel the run; sampled in every non-IDLE state.
- `Mode` in, 1: 0 = SAD (|a-b|), 1 = SSD ((a-b)^2); latched on Go.
- `A_Data`, `B_Data` in, D_WIDTH: read data, valid the cycle after `I_En`.
- `A_Addr`, `B_Addr` out, A_WIDTH: pixel address (A and B always equal).
- `I_En`, `I_RW` out, 1: input-memory enable; I_RW is 0 = read.
- `C_Addr` out, C_WIDTH: score write address.
- `O_En`, `O_RW` out, 1: score-memory enable; O_RW is 1 = write.
- `SAD_Out` out, 32: score write data.
- `Busy` out, 1: high in all states except IDLE.
- `Done` out, 1: single-cycle completion pulse.
- `Best_Idx` out, C_WIDTH: index of the minimum-score block.
- `Best_Val` out, 32: minimum score.

## Operation
- States: IDLE, INIT, READ, ACC, WRITE, FIN. State and counters are registered. All outputs are registered or decoded from registered state only.
- Counters: I (A_WIDTH, pixel address), J (pixels done in the current block), K (block index).
- IDLE with Go=1: latch Mode; I<=0, K<=0; set Best_Val to all-ones and Best_Idx to 0; go to INIT.
- IDLE with Go=0: stay in IDLE.
- INIT: Sum<=0, J<=0; go to READ.
- READ: A_Addr=B_Addr=I, I_En=1, I_RW=0; go to ACC.
- ACC: add the term for A_Data/B_Data to Sum; I<=I+1, J<=J+1.
  - If J==BLK_PIXELS-1, go to WRITE; otherwise go to READ.
- WRITE: O_En=1, O_RW=1, C_Addr=K, SAD_Out=Sum.
  - If Sum < Best_Val (strict, so the earliest block wins ties), update Best_Val and Best_Idx.
  - If K==NUM_BLKS-1, go to FIN; otherwise K<=K+1 and go to INIT.
- FIN: Done=1 for one cycle; go to IDLE. Best_Idx/Best_Val hold until the next Go.
- Arithmetic:
  - Difference is unsigned absolute, D_WIDTH bits.
  - SSD term is 2*D_WIDTH bits.
  - Sum is 32 bits and saturates at 32'hFFFF_FFFF; it never wraps.
- Abort=1 in any non-IDLE state: go to IDLE next cycle.
  - No WRITE or Done is produced; enables drop immediately.
  - Best_Idx/Best_Val hold their partial values.
  - Abort has priority over every other transition, including the final WRITE.
- Go while Busy: ignored.
- Rst while running: same as cold reset; the run is discarded.
- Mode changes mid-run: no effect.

## Timing
- Reset values:
  - State = IDLE; I, J, K = 0; Sum = 0.
  - A_Addr, B_Addr, C_Addr = 0.
  - I_En, I_RW, O_En, O_RW, Done, Busy = 0.
  - SAD_Out = 0, Best_Idx = 0, Best_Val = 32'hFFFF_FFFF.
- Memory read latency is 1 cycle: data for a READ-cycle address is consumed in the following ACC cycle.
- Each pixel takes 2 cycles. Each block takes 2*BLK_PIXELS+2 cycles (INIT + READ/ACC pairs + WRITE).
- Go sampled at edge 0 gives INIT in cycle 1. Done is high in cycle NUM_BLKS*(2*BLK_PIXELS+2)+1. Busy falls the cycle after Done.
- Outside READ, I_En=0 and A_Addr/B_Addr=0. Outside WRITE, O_En=0, C_Addr=0 and SAD_Out=0.
- A new Go is accepted in the first IDLE cycle after FIN, so runs can be back-to-back.

## Test plan
- BLK_PIXELS=4, NUM_BLKS=2, SAD, A={10,20,30,40,5,5,5,5}, B={12,18,30,50,5,5,5,9} -> writes 14 at C_Addr 0 and 4 at C_Addr 1; Best_Idx=1, Best_Val=4; Done in cycle 21.
- Same data, Mode=1 (SSD) -> scores 108 and 16; Best_Idx=1.
- D_WIDTH=8, SSD, BLK_PIXELS=70000 (A_WIDTH=17), all A=255, B=0 -> score saturates at 32'hFFFF_FFFF and does not wrap.
- Equal scores in all blocks -> Best_Idx=0.
- Abort in the ACC cycle of block 1 -> IDLE next cycle; no second WRITE, no Done; a new Go restarts from address 0.
- Rst asserted mid-READ -> every output at its reset value on the next cycle. Go pulsed while Busy -> no restart, and the Done timing is unchanged.

Source files
------------

// File: rtl/sad_engine_param.sv
// sad_engine_param
// ----------------
// Block-matching score engine. It streams NUM_BLKS consecutive blocks of
// BLK_PIXELS pixels from two read-only frame memories (A = current,
// B = reference). One 32-bit score per block is written to the score
// memory (C). The engine tracks the lowest-scoring block.
// The score is SAD (|a-b|) or SSD ((a-b)^2), selected by Mode when Go is
// accepted. The accumulator saturates at 32'hFFFF_FFFF.
//
// Ports
//   Clk, Rst          : clock and synchronous active-high reset
//   Go, Abort, Mode   : start request (IDLE only), cancel (non-IDLE), SAD/SSD select
//   A_Data, B_Data    : pixel read data, valid the cycle after I_En
//   A_Addr, B_Addr    : pixel address (always equal), driven only while reading
//   I_En, I_RW        : input-memory enable, I_RW = 0 (read)
//   C_Addr, SAD_Out   : score write address / data, driven only while writing
//   O_En, O_RW        : score-memory enable, O_RW = 1 (write)
//   Busy, Done        : not-idle flag, one-cycle completion pulse
//   Best_Idx, Best_Val: index and value of the minimum score of the run
// Every output comes straight from a flop.
module sad_engine_param #(
  parameter int D_WIDTH    = 8,
  parameter int A_WIDTH    = 15,
  parameter int C_WIDTH    = 7,
  parameter int BLK_PIXELS = 256,
  parameter int NUM_BLKS   = 128
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic               Abort,
  input  logic               Mode,
  input  logic [D_WIDTH-1:0] A_Data,
  input  logic [D_WIDTH-1:0] B_Data,
  output logic [A_WIDTH-1:0] A_Addr,
  output logic [A_WIDTH-1:0] B_Addr,
  output logic               I_En,
  output logic               I_RW,
  output logic [C_WIDTH-1:0] C_Addr,
  output logic               O_En,
  output logic               O_RW,
  output logic [31:0]        SAD_Out,
  output logic               Busy,
  output logic               Done,
  output logic [C_WIDTH-1:0] Best_Idx,
  output logic [31:0]        Best_Val
);

  localparam int J_WIDTH = (BLK_PIXELS > 1) ? $clog2(BLK_PIXELS) : 1;
  localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(BLK_PIXELS - 1);
  localparam logic [C_WIDTH-1:0] K_LAST = C_WIDTH'(NUM_BLKS - 1);
  localparam int T_WIDTH = 2 * D_WIDTH;
  // Extended adder width: one bit above the wider of the sum and the term,
  // so the carry out is never lost before the saturation test.
  localparam int EXT_W = (T_WIDTH + 1 > 33) ? T_WIDTH + 1 : 33;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_READ  = 3'd2,
    S_ACC   = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Unsigned absolute difference of two pixels.
  function automatic logic [D_WIDTH-1:0] abs_diff(input logic [D_WIDTH-1:0] a,
                                                  input logic [D_WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Per-pixel term: the difference itself (SAD) or its square (SSD).
  function automatic logic [T_WIDTH-1:0] pixel_term(input logic [D_WIDTH-1:0] diff,
                                                    input logic ssd);
    logic [T_WIDTH-1:0] dw;
    dw = T_WIDTH'(diff);
    return ssd ? (dw * dw) : dw;
  endfunction

  // Accumulate with clamping at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [T_WIDTH-1:0] term);
    logic [EXT_W-1:0] s;
    s = EXT_W'(acc) + EXT_W'(term);
    return (s > EXT_W'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] i_q, i_d;
  logic [J_WIDTH-1:0] j_q, j_d;
  logic [C_WIDTH-1:0] k_q, k_d;
  logic [31:0]        sum_q, sum_d;
  logic               mode_q, mode_d;
  logic [C_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [31:0]        best_val_q, best_val_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic               i_en_q, i_en_d;
  logic               i_rw_q, i_rw_d;
  logic [C_WIDTH-1:0] c_addr_q, c_addr_d;
  logic               o_en_q, o_en_d;
  logic               o_rw_q, o_rw_d;
  logic [31:0]        sad_out_q, sad_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [T_WIDTH-1:0] term_s;

  // Next-state, counter, accumulator and best-match logic.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    sum_d      = sum_q;
    mode_d     = mode_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    term_s     = pixel_term(abs_diff(A_Data, B_Data), mode_q);

    // Abort outranks every transition, so the best-match registers keep
    // whatever partial result they already hold.
    if ((state_q != S_IDLE) && Abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Go) begin
            mode_d     = Mode;
            i_d        = '0;
            k_d        = '0;
            best_val_d = 32'hFFFF_FFFF;
            best_idx_d = '0;
            state_d    = S_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_INIT: begin
          sum_d   = 32'd0;
          j_d     = '0;
          state_d = S_READ;
        end
        S_READ: begin
          state_d = S_ACC;
        end
        S_ACC: begin
          sum_d = sat_add(sum_q, term_s);
          i_d   = i_q + A_WIDTH'(1);
          j_d   = j_q + J_WIDTH'(1);
          if (j_q == J_LAST) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
        S_WRITE: begin
          // Strict compare: on a tie the earlier block keeps the title.
          if (sum_q < best_val_q) begin
            best_val_d = sum_q;
            best_idx_d = k_q;
          end else begin
            best_val_d = best_val_q;
            best_idx_d = best_idx_q;
          end
          if (k_q == K_LAST) begin
            state_d = S_FIN;
          end else begin
            k_d     = k_q + C_WIDTH'(1);
            state_d = S_INIT;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state, so that the registered outputs
  // line up with the state they belong to.
  always_comb begin
    i_en_d    = (state_d == S_READ);
    i_rw_d    = 1'b0;
    addr_d    = (state_d == S_READ) ? i_d : '0;
    o_en_d    = (state_d == S_WRITE);
    o_rw_d    = (state_d == S_WRITE);
    c_addr_d  = (state_d == S_WRITE) ? k_d : '0;
    sad_out_d = (state_d == S_WRITE) ? sum_d : 32'd0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FIN);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      sum_q      <= 32'd0;
      mode_q     <= 1'b0;
      best_idx_q <= '0;
      best_val_q <= 32'hFFFF_FFFF;
      addr_q     <= '0;
      i_en_q     <= 1'b0;
      i_rw_q     <= 1'b0;
      c_addr_q   <= '0;
      o_en_q     <= 1'b0;
      o_rw_q     <= 1'b0;
      sad_out_q  <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      sum_q      <= sum_d;
      mode_q     <= mode_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      addr_q     <= addr_d;
      i_en_q     <= i_en_d;
      i_rw_q     <= i_rw_d;
      c_addr_q   <= c_addr_d;
      o_en_q     <= o_en_d;
      o_rw_q     <= o_rw_d;
      sad_out_q  <= sad_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign A_Addr   = addr_q;
  assign B_Addr   = addr_q;
  assign I_En     = i_en_q;
  assign I_RW     = i_rw_q;
  assign C_Addr   = c_addr_q;
  assign O_En     = o_en_q;
  assign O_RW     = o_rw_q;
  assign SAD_Out  = sad_out_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Best_Idx = best_idx_q;
  assign Best_Val = best_val_q;

endmodule

// File: tb/tb_sad_engine_param.sv
// Directed bench for sad_engine_param.
// dut1 : 8-bit pixels, 4 pixels/block, 2 blocks.
// dut2 : 16-bit pixels, SSD, 2 pixels/block, 1 block. Used to saturate the sum.
module tb_sad_engine_param;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst, Go, Abort, Mode;
  logic go2, abort2, mode2;

  logic [7:0]  a_data, b_data;
  logic [2:0]  a_addr, b_addr;
  logic        i_en, i_rw, o_en, o_rw, busy, done;
  logic        c_addr, best_idx;
  logic [31:0] sad_out, best_val;

  logic [15:0] a2_data, b2_data;
  logic        a2_addr, b2_addr;
  logic        i2_en, i2_rw, o2_en, o2_rw, busy2, done2;
  logic        c2_addr, best2_idx;
  logic [31:0] sad2_out, best2_val;

  logic [7:0]  mem_a [8];
  logic [7:0]  mem_b [8];
  logic [15:0] mem2_a [2];
  logic [15:0] mem2_b [2];

  int checks = 0;
  int errors = 0;

  sad_engine_param #(.D_WIDTH(8), .A_WIDTH(3), .C_WIDTH(1),
                     .BLK_PIXELS(4), .NUM_BLKS(2)) dut1 (
    .Clk(Clk), .Rst(Rst), .Go(Go), .Abort(Abort), .Mode(Mode),
    .A_Data(a_data), .B_Data(b_data), .A_Addr(a_addr), .B_Addr(b_addr),
    .I_En(i_en), .I_RW(i_rw), .C_Addr(c_addr), .O_En(o_en), .O_RW(o_rw),
    .SAD_Out(sad_out), .Busy(busy), .Done(done),
    .Best_Idx(best_idx), .Best_Val(best_val));

  sad_engine_param #(.D_WIDTH(16), .A_WIDTH(1), .C_WIDTH(1),
                     .BLK_PIXELS(2), .NUM_BLKS(1)) dut2 (
    .Clk(Clk), .Rst(Rst), .Go(go2), .Abort(abort2), .Mode(mode2),
    .A_Data(a2_data), .B_Data(b2_data), .A_Addr(a2_addr), .B_Addr(b2_addr),
    .I_En(i2_en), .I_RW(i2_rw), .C_Addr(c2_addr), .O_En(o2_en), .O_RW(o2_rw),
    .SAD_Out(sad2_out), .Busy(busy2), .Done(done2),
    .Best_Idx(best2_idx), .Best_Val(best2_val));

  // One-cycle-latency frame memories.
  always @(posedge Clk) begin
    if (i_en && !i_rw) begin
      a_data <= mem_a[a_addr];
      b_data <= mem_b[b_addr];
    end
    if (i2_en && !i2_rw) begin
      a2_data <= mem2_a[a2_addr];
      b2_data <= mem2_b[b2_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic load_ref;
    logic [7:0] va [8];
    logic [7:0] vb [8];
    va = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 8'd5, 8'd5, 8'd5};
    vb = '{8'd12, 8'd18, 8'd30, 8'd50, 8'd5, 8'd5, 8'd5, 8'd9};
    for (int n = 0; n < 8; n++) begin
      mem_a[n] = va[n];
      mem_b[n] = vb[n];
    end
  endtask

  // Full run on dut1 from IDLE. Mode is flipped right after start.
  // An optional Go pulse is given while busy.
  task automatic run1(input logic m, input logic [31:0] e0, input logic [31:0] e1,
                      input logic eidx, input logic [31:0] ebest,
                      input int go_busy_at, input string tag);
    int cyc;
    int nw;
    int nrd;
    logic seen;
    Mode = m;
    Go = 1'b1;
    tick;
    Go = 1'b0;
    Mode = ~m;
    cyc = 1;
    nw = 0;
    nrd = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (o_en) begin
        chk({tag, "_orw"}, o_rw, 1);
        chk({tag, "_caddr"}, c_addr, nw);
        chk({tag, "_score"}, sad_out, (nw == 0) ? e0 : e1);
        nw++;
      end
      if (i_en) begin
        chk({tag, "_raddr_a"}, a_addr, nrd);
        chk({tag, "_raddr_b"}, b_addr, nrd);
        nrd++;
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        Go = (cyc == go_busy_at);
        tick;
        cyc++;
      end
    end
    Go = 1'b0;
    Mode = m;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_done_cycle"}, cyc, 21);
    chk({tag, "_nwrites"}, nw, 2);
    chk({tag, "_nreads"}, nrd, 8);
    chk({tag, "_best_idx"}, best_idx, eidx);
    chk({tag, "_best_val"}, best_val, ebest);
    tick;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_after"}, done, 0);
  endtask

  initial begin
    int cyc;
    int nw;
    logic seen;
    logic bad;

    Rst = 1'b1; Go = 1'b0; Abort = 1'b0; Mode = 1'b0;
    go2 = 1'b0; abort2 = 1'b0; mode2 = 1'b1;
    a_data = 8'd0; b_data = 8'd0; a2_data = 16'd0; b2_data = 16'd0;
    load_ref;
    mem2_a[0] = 16'hFFFF; mem2_a[1] = 16'hFFFF;
    mem2_b[0] = 16'h0000; mem2_b[1] = 16'h0000;
    tick;
    tick;
    Rst = 1'b0;

    // Reset values
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_i_en", i_en, 0);
    chk("rst_i_rw", i_rw, 0);
    chk("rst_o_en", o_en, 0);
    chk("rst_o_rw", o_rw, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_b_addr", b_addr, 0);
    chk("rst_c_addr", c_addr, 0);
    chk("rst_sad_out", sad_out, 0);
    chk("rst_best_idx", best_idx, 0);
    chk("rst_best_val", best_val, 32'hFFFF_FFFF);
    chk("rst2_i_en", i2_en, 0);
    chk("rst2_o_rw", o2_rw, 0);
    chk("rst2_busy", busy2, 0);

    // SAD run with a Go pulse while busy; SSD back-to-back; tie case
    run1(1'b0, 32'd14, 32'd4, 1'b1, 32'd4, 5, "sad");
    run1(1'b1, 32'd108, 32'd16, 1'b1, 32'd16, -1, "ssd");
    for (int n = 0; n < 8; n++) begin
      mem_a[n] = 8'd7;
      mem_b[n] = 8'd4;
    end
    run1(1'b0, 32'd12, 32'd12, 1'b0, 32'd12, -1, "tie");
    load_ref;

    // Abort in the ACC cycle of block 1 (cycle 13)
    Mode = 1'b0;
    Go = 1'b1;
    tick;
    Go = 1'b0;
    repeat (11) tick;
    chk("abort_read_en", i_en, 1);
    chk("abort_read_addr", a_addr, 4);
    tick;
    chk("abort_acc_i_en", i_en, 0);
    Abort = 1'b1;
    tick;
    Abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_i_en", i_en, 0);
    chk("abort_o_en", o_en, 0);
    bad = 1'b0;
    repeat (10) begin
      if (o_en || done || busy) bad = 1'b1;
      tick;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_best_idx", best_idx, 0);
    chk("abort_best_val", best_val, 32'd14);

    // Restart from address 0, then reset in the READ cycle
    Go = 1'b1;
    tick;
    Go = 1'b0;
    chk("restart_busy", busy, 1);
    tick;
    chk("restart_i_en", i_en, 1);
    chk("restart_addr", a_addr, 0);
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_i_en", i_en, 0);
    chk("midrst_a_addr", a_addr, 0);
    chk("midrst_o_en", o_en, 0);
    chk("midrst_c_addr", c_addr, 0);
    chk("midrst_sad_out", sad_out, 0);
    chk("midrst_done", done, 0);
    chk("midrst_best_idx", best_idx, 0);
    chk("midrst_best_val", best_val, 32'hFFFF_FFFF);
    tick;
    chk("midrst_stays_idle", busy, 0);

    // SSD saturation: two terms of 0xFFFE0001 clamp to all-ones
    go2 = 1'b1;
    tick;
    go2 = 1'b0;
    cyc = 1;
    nw = 0;
    seen = 1'b0;
    while (!seen && cyc < 50) begin
      if (o2_en) begin
        chk("sat_caddr", c2_addr, 0);
        chk("sat_score", sad2_out, 32'hFFFF_FFFF);
        nw++;
      end
      if (done2) begin
        seen = 1'b1;
      end else begin
        tick;
        cyc++;
      end
    end
    chk("sat_done_seen", seen, 1);
    chk("sat_done_cycle", cyc, 7);
    chk("sat_nwrites", nw, 1);
    chk("sat_best_idx", best2_idx, 0);
    chk("sat_best_val", best2_val, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
